// File: rtl/uart_tx_fifo_feeder.sv
// Byte FIFO that feeds uart_tx one launch at a time,
// pacing each transfer on the UART busy handshake.
module uart_tx_fifo_feeder #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush,
  input  logic              clr_ovf,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              idle
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    ACK    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_level;
  logic              r_ovf;
  logic [DATA_W-1:0] r_tx_data;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_ovf_set;

  assign w_full    = (r_level == (ADDR_W+1)'(DEPTH));
  assign w_empty   = (r_level == '0);
  assign w_push    = wr_en && !w_full && !flush;
  assign w_ovf_set = wr_en && w_full && !flush;
  assign w_pop     = (r_state == IDLE) && !w_empty
                     && !tx_busy && !flush;

  // storage has no reset; contents are only valid below level
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_ovf     <= 1'b0;
      r_tx_data <= '0;
      r_state   <= IDLE;
    end else begin
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_push)
          r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
        if (w_push && !w_pop)
          r_level <= r_level + (ADDR_W+1)'(1);
        else if (w_pop && !w_push)
          r_level <= r_level - (ADDR_W+1)'(1);
      end

      if (w_ovf_set)
        r_ovf <= 1'b1;
      else if (clr_ovf)
        r_ovf <= 1'b0;

      if (w_pop)
        r_tx_data <= r_mem[r_rd_ptr];

      unique case (r_state)
        IDLE:   if (w_pop) r_state <= LAUNCH;
        LAUNCH: r_state <= ACK;
        ACK:    if (tx_busy) r_state <= DONE;
        DONE:   if (!tx_busy) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx_start = (r_state == LAUNCH);
  assign tx_data  = r_tx_data;
  assign full     = w_full;
  assign empty    = w_empty;
  assign level    = r_level;
  assign overflow = r_ovf;
  assign idle     = w_empty && (r_state == IDLE) && !tx_busy;

endmodule
